imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Boot-time writer for instruction memory; the fetch stage only reads it. Takes a framed byte
//   stream over valid/ready and packs bytes into little-endian 32-bit words.
// - Writes each word to consecutive word addresses through a single-cycle write port.
// - Holds the core halted (cpu_hold) until a complete, valid image is in memory.
// PARAMETERS
// - ADDR_W     8     byte-address width of instruction memory (matches PC width)
// - MAX_WORDS  64    words accepted per image; must be <= 2**ADDR_W/4
// - SYNC_BYTE  8'hA5 frame start marker
// PORTS
// - clk        in   1       processor clock; every register updates on its rising edge
// - rst        in   1       synchronous, active-high reset
// - in_data    in   8       stream byte
// - in_valid   in   1       in_data valid
// - in_ready   out  1       loader accepts a byte; transfer = in_valid & in_ready
// - load_req   in   1       re-arm for a new image (honoured in DONE/ERR only)
// - wr_en      out  1       instruction-memory write strobe, one-cycle pulse
// - wr_addr    out  ADDR_W  byte address of the word, always 4-aligned
// - wr_data    out  32      word; first received byte in [7:0]
// - cpu_hold   out  1       1 = core must not fetch/retire
// - done       out  1       image loaded and accepted (level)
// - err        out  1       frame rejected (level)
// BEHAVIOUR
// - Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 1, done 0, err 0.
//   in_ready is decoded from state, so it is 1 in the cycle after reset.
// - Reset mid-frame: partial word discarded, byte/word counters cleared. Words already written stay in memory.
// - States:
//   - IDLE: discard bytes until one equals SYNC_BYTE -> LEN.
//   - LEN: byte = N. N==0 or N>MAX_WORDS -> ERR; else latch N, clear word count -> DATA.
//   - DATA: accept bytes; lane = byte count mod 4.
//     - On the 4th byte, register wr_en=1, wr_data, wr_addr=4*word_idx for the next cycle.
//     - Write latency is 1 cycle after the 4th handshake.
//     - After word N-1: with LOADER_CKSUM_EN -> CKSUM, else -> DONE.
//   - CKSUM: compare the byte with the checksum. Match -> DONE, else -> ERR.
//   - DONE: cpu_hold=0, done=1, in_ready=0.
//   - ERR: cpu_hold=1, err=1, in_ready=0.
// - in_ready is 1 in IDLE, LEN, DATA and CKSUM. There is no memory backpressure, so a byte can
//   be accepted every cycle, including the cycle wr_en is high.
// - load_req in DONE or ERR -> IDLE on the next edge: done/err clear and cpu_hold rises on that edge.
//   load_req in any other state is ignored.
// - wr_addr is word_idx<<2, which never wraps because N<=MAX_WORDS. Upper address bits are zero-filled.
// - in_valid low in the middle of a word stalls without timeout. Lane state is held.
// CONFIGURATION
// - LOADER_CKSUM_EN defined:
//   - A trailing byte is required after the payload.
//   - Checksum = 8-bit modulo-256 sum of all 4N payload bytes (SYNC and LEN excluded).
//   - Checksum register clears on entry to LEN.
// - LOADER_CKSUM_EN undefined:
//   - No CKSUM state and no checksum register.
//   - DATA -> DONE directly after the last word's write is issued. done rises the cycle wr_en pulses.
// STRUCTURE
// - Shared include loader_defs.vh: state encodings (IDLE, LEN, DATA, CKSUM, DONE, ERR; 3-bit), SYNC_BYTE default.
// - Sub-module imem_word_pack: 2-bit lane counter and 32-bit shift/assemble register.
//   - Inputs: byte and strobe. Outputs: word and word_valid pulse. Synchronous clear.
// - Top level holds the FSM, word index, length, checksum and output registers.
// TESTING
// - Reset then [A5,01,13,00,00,00] -> one wr_en pulse, wr_addr 0x00, wr_data 0x00000013,
//   done=1, cpu_hold=0 (no CKSUM).
// - [00,FF,A5,02, 8 bytes] -> leading 00,FF dropped. Writes at 0x00 and 0x04, little-endian packing checked.
// - LEN=0 and LEN=65 -> err=1, cpu_hold=1, no wr_en. load_req -> IDLE, err=0.
// - CKSUM_EN with [A5,01,01,02,03,04,0A] -> done. Trailing byte 0B instead -> err, word still written.
// - Random in_valid gaps within words -> same writes as the gap-free stream. rst during DATA ->
//   cpu_hold=1, next frame starts at wr_addr 0.
// - load_req in DONE, then a new 1-word image -> cpu_hold high during reload, memory word 0 overwritten.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state encodings and default parameters
package imem_loader_pkg;

    localparam int          DEF_ADDR_W    = 8;
    localparam int          DEF_MAX_WORDS = 64;
    localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // The loader takes bytes in every state except the two terminal ones.
    function automatic logic state_accepts(input state_e st);
        return (st == ST_IDLE) || (st == ST_LEN) || (st == ST_DATA) || (st == ST_CKSUM);
    endfunction

endpackage

// File: rtl/imem_word_pack.sv
// rtl/imem_word_pack.sv - packs strobed bytes into little-endian 32-bit words
module imem_word_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  in_byte,
    input  logic        strobe,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] data_q, data_d;

    // The fourth byte bypasses the register so the word is available on its handshake.
    assign word       = {in_byte, data_q};
    assign word_valid = strobe && (lane_q == 2'd3);

    always_comb begin
        lane_d = lane_q;
        data_d = data_q;
        if (clr) begin
            lane_d = 2'd0;
            data_d = 24'd0;
        end else if (strobe) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    data_d[7:0]   = in_byte;
                2'd1:    data_d[15:8]  = in_byte;
                2'd2:    data_d[23:16] = in_byte;
                default: data_d        = data_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'd0;
            data_q <= 24'd0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader; LOADER_CKSUM_EN adds a trailing checksum byte
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = DEF_ADDR_W,
    parameter int         MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   word_idx_q, word_idx_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
`ifdef LOADER_CKSUM_EN
    logic [7:0]         cksum_q, cksum_d;
`endif

    logic               xfer;
    logic               pack_strobe;
    logic               pack_clr;
    logic [31:0]        pack_word;
    logic               pack_valid;
    logic [ADDR_W-1:0]  idx_ext;

    assign in_ready    = state_accepts(state_q);
    assign xfer        = in_valid && in_ready;
    assign pack_strobe = xfer && (state_q == ST_DATA);
    // Any exit from DATA drops a partial word.
    assign pack_clr    = (state_q != ST_DATA);
    assign idx_ext     = ADDR_W'(word_idx_q);

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);
    assign cpu_hold = (state_q != ST_DONE);

    imem_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (pack_clr),
        .in_byte    (in_data),
        .strobe     (pack_strobe),
        .word       (pack_word),
        .word_valid (pack_valid)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef LOADER_CKSUM_EN
        cksum_d    = cksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
`ifdef LOADER_CKSUM_EN
                    cksum_d = 8'd0;
`endif
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if ((in_data == 8'd0) || (int'(in_data) > MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d      = CNT_W'(in_data);
                        word_idx_d = '0;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef LOADER_CKSUM_EN
                if (pack_strobe) begin
                    cksum_d = cksum_q + in_data;
                end
`endif
                if (pack_valid) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = pack_word;
                    wr_addr_d  = idx_ext << 2;
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q == len_q - 1'b1) begin
`ifdef LOADER_CKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_CKSUM: begin
`ifdef LOADER_CKSUM_EN
                if (xfer) begin
                    state_d = (in_data == cksum_q) ? ST_DONE : ST_ERR;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (load_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            len_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
`ifdef LOADER_CKSUM_EN
            cksum_q    <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef LOADER_CKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        load_req;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    logic [39:0] exp_q[$];
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .load_req (load_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            logic [39:0] e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e[39:32]));
                check("wr_data", 64'(wr_data), 64'(e[31:0]));
                mem[wr_addr[7:2]] = wr_data;
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        in_valid = 1'b0;
        idle_cycles(gap);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Sends SYNC, N, and the words little-endian; pushes each expected write as its 4th byte goes out.
    task automatic load_image(input logic [31:0] words[$], input int gap_max, input bit good_ck);
        logic [7:0] sum;
        logic [31:0] w;
        sum = 8'd0;
        send_byte(8'hA5, 0);
        send_byte(8'(words.size()), 0);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                if (j == 3) exp_q.push_back({8'(i * 4), w});
                sum = sum + w[j*8 +: 8];
                send_byte(w[j*8 +: 8], $urandom_range(0, gap_max));
            end
        end
`ifdef LOADER_CKSUM_EN
        send_byte(good_ck ? sum : sum + 8'd1, 0);
`else
        check("done_with_wr_en", {62'd0, wr_en, done}, 64'd3);
        if (!good_ck) check("ck_flag_unused", 64'd0, 64'd1);
`endif
    endtask

    initial begin
        logic [31:0] img[$];
        int wc;
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; load_req = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", {wr_en, wr_addr, wr_data, cpu_hold, done, err}, {1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0});

        img = '{32'h0000_0013};
        load_image(img, 0, 1'b1);
        idle_cycles(1);
        check("img1_state", {in_ready, cpu_hold, done, err}, 4'b0010);

        pulse_load_req();
        check("reload_state", {in_ready, cpu_hold, done, err}, 4'b1100);

        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        img = '{32'h4433_2211, 32'h8877_6655};
        load_image(img, 0, 1'b1);
        idle_cycles(1);
        check("img2_done", {cpu_hold, done}, 2'b01);

        pulse_load_req();
        wc = wr_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        check("len0_err", {in_ready, cpu_hold, done, err}, 4'b0101);
        pulse_load_req();
        check("len0_clear", {in_ready, err}, 2'b10);
        send_byte(8'hA5, 0);
        send_byte(8'd65, 0);
        check("len65_err", {in_ready, cpu_hold, done, err}, 4'b0101);
        idle_cycles(2);
        check("len_err_no_write", 64'(wr_cnt), 64'(wc));
        pulse_load_req();
        check("len65_clear", {in_ready, err}, 2'b10);

        load_image(img, 3, 1'b1);
        idle_cycles(1);
        check("gaps_done", {cpu_hold, done}, 2'b01);
        check("gaps_mem1", 64'(mem[1]), 64'h8877_6655);

        pulse_load_req();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        exp_q.push_back({8'h00, 32'hDDCC_BBAA});
        send_byte(8'hAA, 0); send_byte(8'hBB, 1); send_byte(8'hCC, 0); send_byte(8'hDD, 2);
        send_byte(8'hEE, 0); send_byte(8'h11, 0);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        check("midrst_hold", {in_ready, cpu_hold, done, err}, 4'b1100);
        img = '{32'hCAFE_F00D};
        load_image(img, 2, 1'b1);
        idle_cycles(1);
        check("midrst_mem0", 64'(mem[0]), 64'hCAFE_F00D);

        pulse_load_req();
        check("reload_hold", 64'(cpu_hold), 64'd1);
        img = '{32'h0BAD_BEEF};
        load_image(img, 0, 1'b1);
        idle_cycles(1);
        check("overwrite_mem0", 64'(mem[0]), 64'h0BAD_BEEF);
        check("overwrite_done", {cpu_hold, done}, 2'b01);

`ifdef LOADER_CKSUM_EN
        pulse_load_req();
        img = '{32'h0403_0201};
        load_image(img, 0, 1'b1);
        idle_cycles(1);
        check("ck_good", {cpu_hold, done, err}, 3'b010);
        pulse_load_req();
        wc = wr_cnt;
        load_image(img, 1, 1'b0);
        idle_cycles(1);
        check("ck_bad", {cpu_hold, done, err}, 3'b101);
        check("ck_bad_written", 64'(wr_cnt), 64'(wc + 1));
`endif

        idle_cycles(3);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
